// File: rtl/wb_port_master_pkg.sv
// Shared types for the request-queueing Wishbone port master: FSM states,
// the queued request record and default widths/timeout.
package wb_master_pkg;

  localparam int REQ_ADDR_W  = 11;
  localparam int REQ_DATA_W  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]            we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/wb_port_master_if.sv
// Core request/response channels plus the Wishbone master bus for one RAM port.
// The master modport is the port master's view; slave is the environment's.
interface wb_port_master_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [3:0]        wb_we_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              wb_stall_i;
  logic              wb_ack_i;
  logic [DATA_W-1:0] wb_data_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i,
    input  wb_stall_i, wb_ack_i, wb_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i,
    output wb_stall_i, wb_ack_i, wb_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/wb_port_master_req_fifo.sv
// Synchronous request FIFO; pointers wrap naturally since DEPTH is a power of two.
module req_fifo
  import wb_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  req_t             wr_data,
  output req_t             rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  req_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage; only slots between the pointers are ever read, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_master.sv
// Queues core requests and issues them one at a time as pipelined Wishbone
// cycles, returning read data, write completion or a timeout error.
module wb_port_master
  import wb_master_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = REQ_ADDR_W,
  parameter int DATA_W  = REQ_DATA_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              RST,
  wb_port_master_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state_r, state_s;
  req_t              issue_r, issue_s;
  req_t              push_data_s;
  req_t              head_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic              cyc_r, cyc_s;
  logic              stb_r, stb_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0] rsp_data_r, rsp_data_s;
  logic              rsp_err_r, rsp_err_s;
  logic              pop_s;
  logic              push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign push_data_s.we   = bus.req_we_i;
  assign push_data_s.addr = REQ_ADDR_W'(bus.req_addr_i);
  assign push_data_s.data = REQ_DATA_W'(bus.req_data_i);
  assign push_s           = bus.req_valid_i && !fifo_full_s;

  req_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_req_fifo (
    .clk     (clk),
    .RST     (RST),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (push_data_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign bus.req_ready_o = (fifo_count_s != CNT_W'(DEPTH));
  assign bus.wb_cyc_o    = cyc_r;
  assign bus.wb_stb_o    = stb_r;
  assign bus.wb_we_o     = issue_r.we;
  assign bus.wb_addr_o   = ADDR_W'(issue_r.addr);
  assign bus.wb_data_o   = DATA_W'(issue_r.data);
  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_data_o  = rsp_data_r;
  assign bus.rsp_err_o   = rsp_err_r;

  // Next-state and next-output decode; everything holds unless a branch changes it.
  always_comb begin
    state_s     = state_r;
    issue_s     = issue_r;
    tmo_s       = tmo_r;
    cyc_s       = cyc_r;
    stb_s       = stb_r;
    rsp_valid_s = rsp_valid_r;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          issue_s = head_s;
          tmo_s   = TMO_W'(0);
          cyc_s   = 1'b1;
          stb_s   = 1'b1;
          state_s = REQ;
        end else begin
          cyc_s = 1'b0;
          stb_s = 1'b0;
        end
      end
      REQ, WAIT_ACK: begin
        tmo_s = tmo_r + TMO_W'(1);
        // Ack wins over timeout; an ack while still in REQ completes directly.
        if (bus.wb_ack_i) begin
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_data_s  = (issue_r.we == 4'h0) ? bus.wb_data_i : DATA_W'(0);
          state_s     = RESP;
        end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_data_s  = DATA_W'(0);
          state_s     = RESP;
        end else if ((state_r == REQ) && !bus.wb_stall_i) begin
          stb_s   = 1'b0;
          state_s = WAIT_ACK;
        end else begin
          state_s = state_r;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        cyc_s       = 1'b0;
        stb_s       = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered bus/response outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      issue_r     <= '{we: 4'h0, addr: REQ_ADDR_W'(0), data: REQ_DATA_W'(0)};
      tmo_r       <= TMO_W'(0);
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= DATA_W'(0);
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      issue_r     <= issue_s;
      tmo_r       <= tmo_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule

// File: doc/wb_port_master.md
# wb_port_master

Request-queueing Wishbone master that sits directly upstream of one port (A or B) of the dual-RAM top. It accepts byte-enabled read/write requests from a core over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time as pipelined Wishbone cycles, honouring stall and waiting for ack. It returns each result (read data or write completion, or timeout error) on a valid/ready response channel.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, ≥2
- ADDR_W, 11: byte address width, matching the RAM port address
- DATA_W, 32: data width
- TIMEOUT, 15: maximum cycles from stb assertion to ack before an error response; ≥2

Ports:
- clk  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  FIFO can accept; equals !full
- req_we_i  in  4  byte write enables; 0 = read
- req_addr_i  in  ADDR_W  byte address
- req_data_i  in  DATA_W  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes response
- rsp_data_o  out  DATA_W  read data; 0 for writes and errors
- rsp_err_o  out  1  transaction timed out
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  4  byte enables
- wb_addr_o  out  ADDR_W  address
- wb_data_o  out  DATA_W  write data
- wb_stall_i, wb_ack_i  in  1  slave stall/ack
- wb_data_i  in  DATA_W  slave read data

## Operation
- Push on req_valid_i && req_ready_o; FIFO pointers wrap modulo DEPTH; occupancy count is DEPTH+1 values wide.
- FSM states are IDLE, REQ, WAIT_ACK, RESP. Exactly one outstanding transaction.
- IDLE: if FIFO non-empty, pop the head into the issue register, go to REQ. Otherwise stay.
- REQ: cyc=stb=1, we/addr/data from the issue register. If !wb_stall_i, go to WAIT_ACK (stb drops). An ack in this cycle completes the transaction directly and goes to RESP.
- WAIT_ACK: cyc=1, stb=0. On wb_ack_i, capture wb_data_i (only if we==0, else 0), rsp_err=0, go to RESP.
- Timeout: a counter clears on entering REQ and increments in REQ/WAIT_ACK. When it reaches TIMEOUT-1 without ack, drop cyc/stb, set rsp_err=1, rsp_data=0, go to RESP.
- RESP: rsp_valid_o=1, outputs held stable. On rsp_ready_i, go to IDLE. Pushes continue in any state.
- An ack while cyc=0 (late ack after timeout) is ignored.

## Timing
- Reset (async assert, sync-released by the caller): state IDLE, FIFO empty, count 0. All wb_* outputs, rsp_valid_o, rsp_err_o and rsp_data_o are 0. req_ready_o is 1.
- All wb_* and rsp_* outputs are registered. req_ready_o is decoded from the registered count.
- Minimum latency: push at edge 0, pop/REQ at edge 1, stb accepted at edge 2, ack at edge 3, rsp_valid_o high after edge 3.
- Each stall cycle adds one cycle. Each cycle the response waits for rsp_ready_i adds one cycle, while the FIFO keeps filling.
- Full: req_ready_o=0, and no push occurs even if a pop happens in the same cycle. Simultaneous push and pop when partially full leaves the count unchanged.
- Empty in IDLE: no pop; wb_cyc_o stays 0.
- RST mid-transaction drops cyc/stb immediately. Queued requests are discarded.

## Structure
- Package wb_master_pkg holds:
  - the state enum typedef (IDLE, REQ, WAIT_ACK, RESP)
  - the packed request struct {we[3:0], addr, data}
  - the default TIMEOUT constant
- Sub-module req_fifo: parameterised synchronous FIFO of the request struct, with push/pop/full/empty/count and the same clk/RST.

## Test plan
- Single read: preload the RAM word at 0x004 with 0xDEADBEEF, push we=0 addr=0x004. Expect one cyc/stb, then rsp_valid_o with rsp_data_o=0xDEADBEEF, rsp_err_o=0, 3 cycles after the push.
- Write then read: push we=4'hF addr=0x408 data=0x12345678, then a read of 0x408. Expect the write response with data 0, then the read response 0x12345678, in order.
- Stall: hold wb_stall_i=1 for 3 cycles in REQ. Expect stb held with stable addr/we/data for 4 cycles and the response delayed by 3.
- Full FIFO with rsp_ready_i=0: push 5 requests (DEPTH=4). Expect req_ready_o=0 once 4 are queued behind the one in RESP, and recovery with all responses in order after rsp_ready_i=1.
- Timeout: never ack. Expect cyc dropped TIMEOUT (15) cycles after stb rose, rsp_err_o=1, rsp_data_o=0; a later stray ack is ignored.
- Reset mid-WAIT_ACK with 2 queued requests: expect cyc=0 and rsp_valid_o=0 immediately, and no responses after release.
